rdmx_frame_checker: RTL and testbench
=====================================

// Module: rdmx_frame_checker
// PURPOSE
//  Parametrised successor to the single-shim frame-data checker. It validates one RDMX ethernet stream from the CMAC
//  against a per-frame pattern stream: frame-data, meta-data, then frame-counter packets per frame. Adds width/shim
//  generalisation, run-on-error mode, saturating error counting and a frame tally. Sits after the CMAC RX, one per shim.
// PARAMETERS
//  DW         512  eth tdata width, bits; power of two, >=512 (whole RDMX header in beat 0)
//  PW         32   pattern width; DW % PW == 0; expected beat = {DW/PW{pattern}}
//  NUM_SHIMS  2    shims sharing a frame; this block sees packets_per_frame/NUM_SHIMS FD packets (power of two)
//  MD_BYTES   128  meta-data payload bytes;  FC_BYTES 4  frame-counter payload bytes
//  ERRCNT_W   16   width of error_count
// PORTS
//  clk                  in   1      sole clock
//  resetn               in   1      asynchronous, active-low reset
//  axis_pattern_tdata   in   PW     frame-data pattern, one word per frame
//  axis_pattern_tvalid  in   1  /  axis_pattern_tready  out  1
//  axis_eth_tdata       in   DW     little-endian CMAC data
//  axis_eth_tvalid/tlast in  1  /  axis_eth_tready      out  1
//  PACKET_SIZE          in   16     FD payload bytes; quasi-static
//  FRAME_SIZE           in   32     bytes per full frame; quasi-static
//  STOP_ON_ERROR        in   1      1: hang on first error; 0: log and continue
//  clear_errors         in   1      1-cycle pulse: clear error, error_count, error_data
//  eth_active           out  1      sticky, set on first axis_eth_tvalid
//  expected_frame_pattern out PW    pattern of frame under check
//  error                out  10     sticky error bits (below)
//  error_count          out  ERRCNT_W  packets with >=1 error, saturating
//  frames_checked       out  32     completed frames, wraps
//  error_data           out  DW     capture of first failing beat/info
//  all_good             out  1      (error == 0)
// BEHAVIOUR
//  Reset: all outputs 0; state GET_PATTERN; both treadys 0 while resetn==0; reset mid-packet discards it.
//  Eth beat registered once (+1 cycle latency) with byte-swapped copy; checks act on the registered beat.
//  Error bits: 0 FD_HDR 1 FD 2 FD_PLEN 3 MD_HDR 4 MD 5 MD_PLEN 6 FC_HDR 7 FC 8 FC_PLEN 9 CFG.
//  Header OK = magic 16'h0122 AND ip4_length == payload + 50. beats_per_fd = PACKET_SIZE/(DW/8).
//  CFG: PACKET_SIZE not power of two in [DW/8, 8192] -> bit 9 set in GET_PATTERN; FD packet count forced to 1.
//  fd_per_shim = (FRAME_SIZE >> log2(PACKET_SIZE)) / NUM_SHIMS; 0 is treated as 1.
//  States: GET_PATTERN -(pattern hs)-> FD_HDR -> FD_DATA -(tlast; count<fd_per_shim)-> FD_HDR
//   FD_DATA -(tlast; count==fd_per_shim)-> MD_HDR -> MD_DATA -(tlast)-> FC_HDR -> FC_DATA -(tlast)-> GET_PATTERN
//   Header beat with tlast set: length error for that class; next state is the following header state.
//  Beat-count check at tlast: FD == beats_per_fd; MD == 1+ceil(MD_BYTES*8/DW); FC == 1.
//  FC: first frame after reset loads expected_fc from tdata[31:0]; later frames expect +1 (wrap 0xFFFFFFFF->0).
//  frames_checked increments on FC_DATA tlast, even when errors occurred.
//  STOP_ON_ERROR=1: any error freezes FSM; eth_tready stays 1 and beats are dropped, so CMAC never backpressures.
//  STOP_ON_ERROR=0: bad header -> DRAIN; discard to tlast, then the header state of the next packet class.
//  error_count +1 per packet with any error, saturating at all-ones. error_data keeps first error only.
//  clear_errors in same cycle as a new error: new error wins (bit set, error_count=1, data captured).
// CONFIGURATION
//  RDMX_ERR_CAPTURE_EN defined: error_data captures failing beat (header: swapped beat; FC: {expected,got};
//   PLEN: beat count). Not defined: error_data tied to 0 and no DW-wide capture register is built.
// STRUCTURE
//  Package rdmx_check_pkg: state enum, error bit indices, RDMX_MAGIC, PACKET_OVERHEAD=50, header field offsets.
//  Sub-module rdmx_hdr_decode: byte swap plus magic/ip4_length extraction, registered, DW-generic.
// TESTING
//  1. DW=512, PACKET_SIZE=256, FRAME_SIZE=4096, 3 clean frames -> fd_per_shim=8; frames_checked=3; error=0.
//  2. Flip 1 bit in FD beat 2, STOP=1 -> error=10'h002; error_count=1; tready stays 1; FSM frozen.
//  3. Same fault, STOP=0 -> error=2, next frame still checked, frames_checked increments, error_count=1.
//  4. FC sequence 0xFFFFFFFE,0xFFFFFFFF,0x0 -> no error; 0x5 next -> bit 7; error_data[63:0]={0x1,0x5}.
//  5. MD header ip4_length 177 (expect 178) -> bit 3; DRAIN to tlast; FC packet then checks correctly.
//  6. PACKET_SIZE=96 -> bit 9; resetn low mid-FD packet -> all outputs 0, tready 0, clean restart.

Source files
------------

// File: rtl/rdmx_check_pkg.sv
// Shared definitions for the RDMX frame checker: FSM encodings, error bit
// positions and the RDMX header layout (byte offsets in network order).
package rdmx_check_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_GET_PATTERN = 3'd0;
    localparam state_t ST_FD_HDR      = 3'd1;
    localparam state_t ST_FD_DATA     = 3'd2;
    localparam state_t ST_MD_HDR      = 3'd3;
    localparam state_t ST_MD_DATA     = 3'd4;
    localparam state_t ST_FC_HDR      = 3'd5;
    localparam state_t ST_FC_DATA     = 3'd6;
    localparam state_t ST_DRAIN       = 3'd7;

    localparam logic [3:0] ERR_FD_HDR  = 4'd0;
    localparam logic [3:0] ERR_FD      = 4'd1;
    localparam logic [3:0] ERR_FD_PLEN = 4'd2;
    localparam logic [3:0] ERR_MD_HDR  = 4'd3;
    localparam logic [3:0] ERR_MD      = 4'd4;
    localparam logic [3:0] ERR_MD_PLEN = 4'd5;
    localparam logic [3:0] ERR_FC_HDR  = 4'd6;
    localparam logic [3:0] ERR_FC      = 4'd7;
    localparam logic [3:0] ERR_FC_PLEN = 4'd8;
    localparam logic [3:0] ERR_CFG     = 4'd9;

    localparam logic [15:0] RDMX_MAGIC      = 16'h0122;
    localparam logic [15:0] PACKET_OVERHEAD = 16'd50;

    // Both fields are big-endian on the wire; offsets count from the first byte of beat 0.
    localparam int HDR_OFF_IP4_LEN = 16;
    localparam int HDR_OFF_MAGIC   = 42;

    function automatic logic [4:0] log2_floor(input logic [15:0] v);
        log2_floor = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) log2_floor = 5'(i);
        end
    endfunction

    function automatic logic is_pow2(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/rdmx_hdr_decode.sv
// Input register for the CMAC beat plus RDMX header field extraction.
// With RDMX_ERR_CAPTURE_EN defined the byte-swapped beat is also exported.
module rdmx_hdr_decode
    import rdmx_check_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] tdata_i,
    input  logic          beat_en_i,
    input  logic          tlast_i,
    output logic          vld_o,
    output logic          last_o,
    output logic [DW-1:0] beat_o,
`ifdef RDMX_ERR_CAPTURE_EN
    output logic [DW-1:0] swap_o,
`endif
    output logic [15:0]   magic_o,
    output logic [15:0]   ip4_len_o
);

    logic [DW-1:0] beat_q;
    logic          vld_q;
    logic          last_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= beat_en_i;
            last_q <= beat_en_i & tlast_i;
            if (beat_en_i) beat_q <= tdata_i;
        end
    end

`ifdef RDMX_ERR_CAPTURE_EN
    always_comb begin
        swap_o = '0;
        for (int i = 0; i < DW/8; i++) begin
            swap_o[DW-1-8*i -: 8] = beat_q[8*i +: 8];
        end
    end
`endif

    assign magic_o   = {beat_q[8*HDR_OFF_MAGIC +: 8],   beat_q[8*(HDR_OFF_MAGIC+1) +: 8]};
    assign ip4_len_o = {beat_q[8*HDR_OFF_IP4_LEN +: 8], beat_q[8*(HDR_OFF_IP4_LEN+1) +: 8]};
    assign vld_o     = vld_q;
    assign last_o    = last_q;
    assign beat_o    = beat_q;

endmodule

// File: rtl/rdmx_frame_checker.sv
// RDMX frame checker: validates FD/MD/FC packets of one shim against a per-frame pattern.
// RDMX_ERR_CAPTURE_EN enables the error_data capture register; otherwise error_data is 0.
//
// state          | meaning
// GET_PATTERN    | waiting for the pattern word of the next frame
// FD_HDR/FD_DATA | frame-data packet header / payload beats
// MD_HDR/MD_DATA | meta-data packet header / payload beats
// FC_HDR/FC_DATA | frame-counter packet header / payload beat
// DRAIN          | discarding a packet with a bad header up to tlast
module rdmx_frame_checker
    import rdmx_check_pkg::*;
#(
    parameter int DW        = 512,
    parameter int PW        = 32,
    parameter int NUM_SHIMS = 2,
    parameter int MD_BYTES  = 128,
    parameter int FC_BYTES  = 4,
    parameter int ERRCNT_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [PW-1:0]       axis_pattern_tdata,
    input  logic                axis_pattern_tvalid,
    output logic                axis_pattern_tready,
    input  logic [DW-1:0]       axis_eth_tdata,
    input  logic                axis_eth_tvalid,
    input  logic                axis_eth_tlast,
    output logic                axis_eth_tready,
    input  logic [15:0]         PACKET_SIZE,
    input  logic [31:0]         FRAME_SIZE,
    input  logic                STOP_ON_ERROR,
    input  logic                clear_errors,
    output logic                eth_active,
    output logic [PW-1:0]       expected_frame_pattern,
    output logic [9:0]          error,
    output logic [ERRCNT_W-1:0] error_count,
    output logic [31:0]         frames_checked,
    output logic [DW-1:0]       error_data,
    output logic                all_good
);

    localparam int            DBYTES_LOG2 = $clog2(DW/8);
    localparam int            SHIM_LOG2   = $clog2(NUM_SHIMS);
    localparam logic [15:0]   MD_BEATS    = 16'(1 + (MD_BYTES*8 + DW - 1) / DW);
    localparam logic [ERRCNT_W-1:0] CNT_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

    logic          b_vld, b_last;
    logic [DW-1:0] beat_q;
    logic [15:0]   hdr_magic, hdr_ip4_len;
`ifdef RDMX_ERR_CAPTURE_EN
    logic [DW-1:0] beat_swap;
`endif

    state_t              state_q, state_d, drain_next_q, drain_next_d;
    logic                halted_q, halted_d, tready_q, active_q;
    logic [PW-1:0]       pattern_q, pattern_d;
    logic [31:0]         fd_cnt_q, fd_cnt_d, fc_exp_q, fc_exp_d, frames_q, frames_d;
    logic [15:0]         beat_cnt_q, beat_cnt_d;
    logic                pkt_err_q, pkt_err_d, fc_seen_q, fc_seen_d;
    logic [9:0]          error_q, error_d, new_err;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d, cnt_base;
    logic                pkt_start, cnt_inc;

    rdmx_hdr_decode #(.DW(DW)) u_hdr_decode (
        .clk       (clk),
        .resetn    (resetn),
        .tdata_i   (axis_eth_tdata),
        .beat_en_i (axis_eth_tvalid & tready_q),
        .tlast_i   (axis_eth_tlast),
        .vld_o     (b_vld),
        .last_o    (b_last),
        .beat_o    (beat_q),
`ifdef RDMX_ERR_CAPTURE_EN
        .swap_o    (beat_swap),
`endif
        .magic_o   (hdr_magic),
        .ip4_len_o (hdr_ip4_len)
    );

    logic        cfg_bad, hdr_ok;
    logic [31:0] fd_raw, fd_per_shim;
    logic [15:0] beats_per_fd, cls_payload;
    logic [3:0]  cls_hdr_bit, cls_plen_bit;
    state_t      cls_data_st, cls_after_st, fd_after_st;
    logic [DW-1:0] exp_beat;

    assign cfg_bad      = !(is_pow2(PACKET_SIZE) && (PACKET_SIZE >= 16'(DW/8)) && (PACKET_SIZE <= 16'd8192));
    assign fd_raw       = (FRAME_SIZE >> log2_floor(PACKET_SIZE)) >> SHIM_LOG2;
    assign fd_per_shim  = (cfg_bad || fd_raw == 32'd0) ? 32'd1 : fd_raw;
    assign beats_per_fd = PACKET_SIZE >> DBYTES_LOG2;
    assign fd_after_st  = (fd_cnt_q + 32'd1 >= fd_per_shim) ? ST_MD_HDR : ST_FD_HDR;
    assign exp_beat     = {(DW/PW){pattern_q}};

    always_comb begin
        cls_payload  = PACKET_SIZE;
        cls_hdr_bit  = ERR_FD_HDR;
        cls_plen_bit = ERR_FD_PLEN;
        cls_data_st  = ST_FD_DATA;
        cls_after_st = fd_after_st;
        case (state_q)
            ST_MD_HDR: begin
                cls_payload  = 16'(MD_BYTES);
                cls_hdr_bit  = ERR_MD_HDR;
                cls_plen_bit = ERR_MD_PLEN;
                cls_data_st  = ST_MD_DATA;
                cls_after_st = ST_FC_HDR;
            end
            ST_FC_HDR: begin
                cls_payload  = 16'(FC_BYTES);
                cls_hdr_bit  = ERR_FC_HDR;
                cls_plen_bit = ERR_FC_PLEN;
                cls_data_st  = ST_FC_DATA;
                cls_after_st = ST_GET_PATTERN;
            end
            default: ;
        endcase
    end

    assign hdr_ok = (hdr_magic == RDMX_MAGIC) && (hdr_ip4_len == cls_payload + PACKET_OVERHEAD);
    assign axis_pattern_tready = tready_q && !halted_q && (state_q == ST_GET_PATTERN);

    always_comb begin
        state_d      = state_q;
        drain_next_d = drain_next_q;
        halted_d     = halted_q;
        pattern_d    = pattern_q;
        fd_cnt_d     = fd_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        fc_exp_d     = fc_exp_q;
        fc_seen_d    = fc_seen_q;
        frames_d     = frames_q;
        new_err      = '0;
        pkt_start    = 1'b0;
        if (!halted_q) begin
            case (state_q)
                ST_GET_PATTERN: if (axis_pattern_tvalid && axis_pattern_tready) begin
                    pattern_d = axis_pattern_tdata;
                    fd_cnt_d  = 32'd0;
                    state_d   = ST_FD_HDR;
                    pkt_start = 1'b1;
                    if (cfg_bad) new_err[ERR_CFG] = 1'b1;
                end
                ST_FD_HDR, ST_MD_HDR, ST_FC_HDR: if (b_vld) begin
                    pkt_start  = 1'b1;
                    beat_cnt_d = 16'd0;
                    if (!hdr_ok) new_err[cls_hdr_bit] = 1'b1;
                    if (b_last || !hdr_ok) begin
                        if (b_last) new_err[cls_plen_bit] = 1'b1;
                        if (state_q == ST_FD_HDR) fd_cnt_d = fd_cnt_q + 32'd1;
                        drain_next_d = cls_after_st;
                        state_d      = b_last ? cls_after_st : ST_DRAIN;
                    end else begin
                        state_d = cls_data_st;
                    end
                end
                ST_FD_DATA: if (b_vld) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_q != exp_beat) new_err[ERR_FD] = 1'b1;
                    if (b_last) begin
                        if (beat_cnt_q + 16'd1 != beats_per_fd) new_err[ERR_FD_PLEN] = 1'b1;
                        fd_cnt_d = fd_cnt_q + 32'd1;
                        state_d  = fd_after_st;
                    end
                end
                // The first meta-data word echoes the frame pattern.
                ST_MD_DATA: if (b_vld) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_cnt_q == 16'd0 && beat_q[PW-1:0] != pattern_q) new_err[ERR_MD] = 1'b1;
                    if (b_last) begin
                        if (beat_cnt_q + 16'd1 != MD_BEATS) new_err[ERR_MD_PLEN] = 1'b1;
                        state_d = ST_FC_HDR;
                    end
                end
                ST_FC_DATA: if (b_vld) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_cnt_q == 16'd0) begin
                        if (fc_seen_q && beat_q[31:0] != fc_exp_q) new_err[ERR_FC] = 1'b1;
                        fc_exp_d  = beat_q[31:0] + 32'd1;
                        fc_seen_d = 1'b1;
                    end
                    if (b_last) begin
                        if (beat_cnt_q != 16'd0) new_err[ERR_FC_PLEN] = 1'b1;
                        frames_d = frames_q + 32'd1;
                        state_d  = ST_GET_PATTERN;
                    end
                end
                default: if (b_vld && b_last) state_d = drain_next_q;
            endcase
            if (|new_err && STOP_ON_ERROR) begin
                halted_d = 1'b1;
                state_d  = state_q;
                frames_d = frames_q;
            end
        end
    end

    assign pkt_err_d = pkt_start ? (|new_err) : (pkt_err_q | (|new_err));
    assign cnt_inc   = (|new_err) && (pkt_start || !pkt_err_q || clear_errors);
    assign cnt_base  = clear_errors ? '0 : err_cnt_q;
    assign err_cnt_d = (cnt_inc && cnt_base != '1) ? cnt_base + CNT_ONE : cnt_base;
    assign error_d   = (clear_errors ? 10'd0 : error_q) | new_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_GET_PATTERN;
            drain_next_q <= ST_GET_PATTERN;
            halted_q     <= 1'b0;
            tready_q     <= 1'b0;
            active_q     <= 1'b0;
            pattern_q    <= '0;
            fd_cnt_q     <= '0;
            beat_cnt_q   <= '0;
            fc_exp_q     <= '0;
            fc_seen_q    <= 1'b0;
            frames_q     <= '0;
            pkt_err_q    <= 1'b0;
            error_q      <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            drain_next_q <= drain_next_d;
            halted_q     <= halted_d;
            tready_q     <= 1'b1;
            active_q     <= active_q | axis_eth_tvalid;
            pattern_q    <= pattern_d;
            fd_cnt_q     <= fd_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            fc_exp_q     <= fc_exp_d;
            fc_seen_q    <= fc_seen_d;
            frames_q     <= frames_d;
            pkt_err_q    <= pkt_err_d;
            error_q      <= error_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef RDMX_ERR_CAPTURE_EN
    logic [DW-1:0] cap_val, err_data_q;
    logic          first_err;

    always_comb begin
        cap_val = '0;
        if (new_err[ERR_FD_HDR] | new_err[ERR_MD_HDR] | new_err[ERR_FC_HDR])
            cap_val = beat_swap;
        else if (new_err[ERR_FC])
            cap_val[63:0] = {fc_exp_q, beat_q[31:0]};
        else if (new_err[ERR_FD] | new_err[ERR_MD])
            cap_val = beat_q;
        else if (new_err[ERR_FD_PLEN] | new_err[ERR_MD_PLEN] | new_err[ERR_FC_PLEN])
            cap_val[15:0] = beat_cnt_d;
        else
            cap_val[15:0] = PACKET_SIZE;
    end

    assign first_err = (|new_err) && (clear_errors || error_q == 10'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           err_data_q <= '0;
        else if (first_err)    err_data_q <= cap_val;
        else if (clear_errors) err_data_q <= '0;
    end

    assign error_data = err_data_q;
`else
    assign error_data = '0;
`endif

    assign axis_eth_tready        = tready_q;
    assign eth_active             = active_q;
    assign expected_frame_pattern = pattern_q;
    assign error                  = error_q;
    assign error_count            = err_cnt_q;
    assign frames_checked         = frames_q;
    // Qualified with tready_q so every output reads 0 while in reset.
    assign all_good               = tready_q && (error_q == 10'd0);

endmodule

// File: tb/tb_rdmx_frame_checker.sv
// Directed bench for rdmx_frame_checker: clean frames, FC wrap, FD/MD/FC faults,
// stop/continue modes, config error and mid-packet reset.
module tb_rdmx_frame_checker;

    localparam int DW = 512;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic [PW-1:0] axis_pattern_tdata;
    logic          axis_pattern_tvalid;
    logic          axis_pattern_tready;
    logic [DW-1:0] axis_eth_tdata;
    logic          axis_eth_tvalid;
    logic          axis_eth_tlast;
    logic          axis_eth_tready;
    logic [15:0]   PACKET_SIZE;
    logic [31:0]   FRAME_SIZE;
    logic          STOP_ON_ERROR;
    logic          clear_errors;
    logic          eth_active;
    logic [PW-1:0] expected_frame_pattern;
    logic [9:0]    error;
    logic [15:0]   error_count;
    logic [31:0]   frames_checked;
    logic [DW-1:0] error_data;
    logic          all_good;

    int n_cmp = 0;
    int n_bad = 0;

    rdmx_frame_checker dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .axis_pattern_tdata     (axis_pattern_tdata),
        .axis_pattern_tvalid    (axis_pattern_tvalid),
        .axis_pattern_tready    (axis_pattern_tready),
        .axis_eth_tdata         (axis_eth_tdata),
        .axis_eth_tvalid        (axis_eth_tvalid),
        .axis_eth_tlast         (axis_eth_tlast),
        .axis_eth_tready        (axis_eth_tready),
        .PACKET_SIZE            (PACKET_SIZE),
        .FRAME_SIZE             (FRAME_SIZE),
        .STOP_ON_ERROR          (STOP_ON_ERROR),
        .clear_errors           (clear_errors),
        .eth_active             (eth_active),
        .expected_frame_pattern (expected_frame_pattern),
        .error                  (error),
        .error_count            (error_count),
        .frames_checked         (frames_checked),
        .error_data             (error_data),
        .all_good               (all_good)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Header with ip4 total length and RDMX magic; bytes 56 and 63 carry markers.
    function automatic logic [DW-1:0] mk_hdr(input logic [15:0] len);
        logic [DW-1:0] b;
        b = '0;
        b[8*12 +: 8] = 8'h08;
        b[8*16 +: 8] = len[15:8];
        b[8*17 +: 8] = len[7:0];
        b[8*42 +: 8] = 8'h01;
        b[8*43 +: 8] = 8'h22;
        b[8*56 +: 8] = 8'hC3;
        b[8*63 +: 8] = 8'h5A;
        return b;
    endfunction

    task automatic eth_beat(input logic [DW-1:0] d, input logic last);
        @(negedge clk);
        axis_eth_tdata  = d;
        axis_eth_tvalid = 1'b1;
        axis_eth_tlast  = last;
    endtask

    task automatic eth_idle(input int n);
        @(negedge clk);
        axis_eth_tvalid = 1'b0;
        axis_eth_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pattern(input logic [PW-1:0] pat);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        axis_pattern_tdata  = pat;
        axis_pattern_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (axis_pattern_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_val("pattern_handshake_timeout", 64'd0, 64'd1);
        @(negedge clk);
        axis_pattern_tvalid = 1'b0;
    endtask

    // 8 FD packets of 4 beats, MD packet of 3 beats, FC packet of 1 beat.
    task automatic send_frame(input logic [31:0] pat, input logic [31:0] fc,
                              input int flip_pkt, input logic [15:0] md_len);
        logic [DW-1:0] d;
        send_pattern(pat);
        for (int p = 0; p < 8; p++) begin
            eth_beat(mk_hdr(16'd306), 1'b0);
            for (int b = 0; b < 4; b++) begin
                d = {(DW/PW){pat}};
                if (p == flip_pkt && b == 2) d[5] = ~d[5];
                eth_beat(d, b == 3);
            end
        end
        eth_beat(mk_hdr(md_len), 1'b0);
        for (int b = 0; b < 3; b++) eth_beat({(DW/PW){pat}}, b == 2);
        eth_beat(mk_hdr(16'd54), 1'b0);
        d = '0;
        d[31:0] = fc;
        eth_beat(d, 1'b1);
        eth_idle(4);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pat_tready"}, 64'(axis_pattern_tready), 64'd0);
        check_val({tag, "_eth_tready"}, 64'(axis_eth_tready), 64'd0);
        check_val({tag, "_eth_active"}, 64'(eth_active), 64'd0);
        check_val({tag, "_exp_pattern"}, 64'(expected_frame_pattern), 64'd0);
        check_val({tag, "_error"}, 64'(error), 64'd0);
        check_val({tag, "_err_count"}, 64'(error_count), 64'd0);
        check_val({tag, "_frames"}, 64'(frames_checked), 64'd0);
        check_val({tag, "_err_data"}, 64'(|error_data), 64'd0);
        check_val({tag, "_all_good"}, 64'(all_good), 64'd0);
    endtask

    logic [63:0] exp_fc_data, exp_fd_data, exp_md_data, exp_cfg_data;

    initial begin
`ifdef RDMX_ERR_CAPTURE_EN
        exp_fc_data  = {32'h0000_0001, 32'h0000_0005};
        exp_fd_data  = {32'hA5A5_0005, 32'hA5A5_0025};
        exp_md_data  = 64'hC300_0000_0000_005A;
        exp_cfg_data = 64'd96;
`else
        exp_fc_data  = 64'd0;
        exp_fd_data  = 64'd0;
        exp_md_data  = 64'd0;
        exp_cfg_data = 64'd0;
`endif
        resetn              = 1'b0;
        axis_pattern_tdata  = '0;
        axis_pattern_tvalid = 1'b0;
        axis_eth_tdata      = '0;
        axis_eth_tvalid     = 1'b0;
        axis_eth_tlast      = 1'b0;
        PACKET_SIZE         = 16'd256;
        FRAME_SIZE          = 32'd4096;
        STOP_ON_ERROR       = 1'b0;
        clear_errors        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_val("eth_tready_after_rst", 64'(axis_eth_tready), 64'd1);
        check_val("all_good_after_rst", 64'(all_good), 64'd1);

        // Three clean frames, FC crossing the 32-bit wrap.
        send_frame(32'hA5A5_0001, 32'hFFFF_FFFE, -1, 16'd178);
        send_frame(32'hA5A5_0002, 32'hFFFF_FFFF, -1, 16'd178);
        send_frame(32'hA5A5_0003, 32'h0000_0000, -1, 16'd178);
        check_val("clean_frames", 64'(frames_checked), 64'd3);
        check_val("clean_error", 64'(error), 64'd0);
        check_val("clean_err_count", 64'(error_count), 64'd0);
        check_val("clean_all_good", 64'(all_good), 64'd1);
        check_val("clean_eth_active", 64'(eth_active), 64'd1);
        check_val("clean_exp_pattern", 64'(expected_frame_pattern), 64'hA5A5_0003);

        // FC jumps 0 -> 5.
        send_frame(32'hA5A5_0004, 32'h0000_0005, -1, 16'd178);
        check_val("fc_error", 64'(error), 64'h080);
        check_val("fc_err_count", 64'(error_count), 64'd1);
        check_val("fc_frames", 64'(frames_checked), 64'd4);
        check_val("fc_err_data", error_data[63:0], exp_fc_data);
        check_val("fc_err_data_hi", 64'(|error_data[DW-1:64]), 64'd0);
        check_val("fc_all_good", 64'(all_good), 64'd0);

        pulse_clear();
        check_val("clear_error", 64'(error), 64'd0);
        check_val("clear_err_count", 64'(error_count), 64'd0);
        check_val("clear_err_data", 64'(|error_data), 64'd0);

        // FD bit flip with run-on-error: logging continues, next frame still checked.
        send_frame(32'hA5A5_0005, 32'h0000_0006, 1, 16'd178);
        check_val("fd_run_error", 64'(error), 64'h002);
        check_val("fd_run_err_count", 64'(error_count), 64'd1);
        check_val("fd_run_frames", 64'(frames_checked), 64'd5);
        check_val("fd_run_err_data", error_data[63:0], exp_fd_data);
        send_frame(32'hA5A5_0006, 32'h0000_0007, -1, 16'd178);
        check_val("fd_run_next_frames", 64'(frames_checked), 64'd6);
        check_val("fd_run_next_error", 64'(error), 64'h002);
        check_val("fd_run_next_count", 64'(error_count), 64'd1);

        pulse_clear();
        // MD header with ip4_length 177: drain, FC still checked.
        send_frame(32'hA5A5_0007, 32'h0000_0008, -1, 16'd177);
        check_val("md_hdr_error", 64'(error), 64'h008);
        check_val("md_hdr_err_count", 64'(error_count), 64'd1);
        check_val("md_hdr_frames", 64'(frames_checked), 64'd7);
        check_val("md_hdr_err_data", error_data[63:0], exp_md_data);

        pulse_clear();
        // FD bit flip with stop-on-error: FSM freezes, eth_tready stays high.
        STOP_ON_ERROR = 1'b1;
        send_frame(32'hA5A5_0009, 32'h0000_0009, 2, 16'd178);
        check_val("stop_error", 64'(error), 64'h002);
        check_val("stop_err_count", 64'(error_count), 64'd1);
        check_val("stop_frames", 64'(frames_checked), 64'd7);
        check_val("stop_eth_tready", 64'(axis_eth_tready), 64'd1);
        check_val("stop_pat_tready", 64'(axis_pattern_tready), 64'd0);
        check_val("stop_exp_pattern", 64'(expected_frame_pattern), 64'hA5A5_0009);

        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst2");
        repeat (2) @(negedge clk);
        STOP_ON_ERROR = 1'b0;
        PACKET_SIZE   = 16'd96;
        resetn        = 1'b1;
        send_pattern(32'h0000_0011);
        @(negedge clk);
        check_val("cfg_error", 64'(error), 64'h200);
        check_val("cfg_err_count", 64'(error_count), 64'd1);
        check_val("cfg_err_data", error_data[63:0], exp_cfg_data);

        // Reset in the middle of an FD packet, then a clean restart.
        eth_beat(mk_hdr(16'd146), 1'b0);
        @(negedge clk);
        axis_eth_tvalid = 1'b0;
        resetn          = 1'b0;
        #1;
        check_reset_outputs("rst3");
        repeat (2) @(negedge clk);
        PACKET_SIZE = 16'd256;
        resetn      = 1'b1;
        send_frame(32'h0000_0022, 32'h0000_0100, -1, 16'd178);
        check_val("restart_error", 64'(error), 64'd0);
        check_val("restart_frames", 64'(frames_checked), 64'd1);
        check_val("restart_all_good", 64'(all_good), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
